// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each operation is issued for one execute cycle, then held as a tagged response until the consumer takes it.
module alu_arbiter #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_f,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_f,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,

    output logic [3:0]    alu_f,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_y,
    input  logic          alu_zf,
    input  logic          alu_of,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [W-1:0]  rsp_y,
    output logic          rsp_zf,
    output logic          rsp_of,

    output logic          busy,
    output logic [CW-1:0] ops_done
);

    // state | meaning
    // IDLE  | arbitrate, accept one request into the ALU input registers
    // EXEC  | ALU inputs held stable; result captured at end of cycle
    // DONE  | response presented until the consumer accepts it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [3:0]      alu_f_q, alu_f_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_y_q, rsp_y_d;
    logic            rsp_zf_q, rsp_zf_d;
    logic            rsp_of_q, rsp_of_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   ops_done_q, ops_done_d;

    logic            grant0, grant1;
    logic            accept0, accept1;
    logic            rsp_hs;

    // On a tie the requester that was not granted last wins; last_grant resets to 1 so req0 wins first.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign accept0    = req0_valid & req0_ready;
    assign accept1    = req1_valid & req1_ready;
    assign rsp_hs     = rsp_valid_q & rsp_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_f_d      = alu_f_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_y_d      = rsp_y_q;
        rsp_zf_d     = rsp_zf_q;
        rsp_of_d     = rsp_of_q;
        ops_done_d   = ops_done_q;

        case (state_q)
            IDLE: begin
                if (accept0) begin
                    alu_f_d      = req0_f;
                    alu_a_d      = req0_a;
                    alu_b_d      = req0_b;
                    rsp_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (accept1) begin
                    alu_f_d      = req1_f;
                    alu_a_d      = req1_a;
                    alu_b_d      = req1_b;
                    rsp_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d  = alu_y;
                rsp_zf_d = alu_zf;
                rsp_of_d = alu_of;
                state_d  = DONE;
            end
            DONE: begin
                if (rsp_hs) begin
                    ops_done_d = ops_done_q + CW'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs registered from the next state so they line up with the state itself.
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            alu_f_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_y_q      <= '0;
            rsp_zf_q     <= 1'b0;
            rsp_of_q     <= 1'b0;
            busy_q       <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_f_q      <= alu_f_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_y_q      <= rsp_y_d;
            rsp_zf_q     <= rsp_zf_d;
            rsp_of_q     <= rsp_of_d;
            busy_q       <= busy_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign alu_f     = alu_f_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zf    = rsp_zf_q;
    assign rsp_of    = rsp_of_q;
    assign busy      = busy_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU, a transaction-level model of
// arbitration/latency, and a negedge monitor that checks every response and status output.
module tb_alu_arbiter;
    localparam int W  = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [3:0]    req0_f = '0, req1_f = '0;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    alu_f;
    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic          alu_zf, alu_of;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zf, rsp_of;
    logic [W-1:0]  rsp_y;
    logic          busy;
    logic [CW-1:0] ops_done;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_f(req0_f), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_f(req1_f), .req1_a(req1_a), .req1_b(req1_b),
        .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_zf(alu_zf), .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_zf(rsp_zf), .rsp_of(rsp_of), .busy(busy), .ops_done(ops_done)
    );

    // Behavioural ALU: returns {y, zf, of}
    function automatic logic [W+1:0] alu_ref(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] y;
        logic         of;
        y  = '0;
        of = 1'b0;
        case (f)
            4'b0000: y = a & b;
            4'b0001: y = a | b;
            4'b0010: begin y = a + b; of = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]); end
            4'b0110: begin y = a - b; of = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]); end
            4'b0111: y = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'b1100: y = ~(a | b);
            default: y = a ^ b;
        endcase
        return {y, (y == '0), of};
    endfunction

    assign {alu_y, alu_zf, alu_of} = alu_ref(alu_f, alu_a, alu_b);

    typedef struct packed {
        logic         id;
        logic [W-1:0] y;
        logic         zf;
        logic         of;
    } exp_t;

    exp_t expq[$];
    int   acc_cyc[$];
    int   acc_id[$];

    int   errors = 0;
    int   checks = 0;
    bit   in_reset = 1'b1;
    bit   outstanding = 1'b0;
    int   age = 0;
    bit   m_last = 1'b1;
    int   hs_count = 0;
    bit   acc0 = 1'b0, acc1 = 1'b0;
    int   cyc = 0;
    int   hs_cyc = -1;
    bit   hold_valid = 1'b0;
    logic [W+2:0] held;
    logic [3:0]   pend_f;
    logic [W-1:0] pend_a, pend_b;
    exp_t last_rsp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit r0, r1;
        exp_t e;
        cyc++;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!in_reset) begin
            if (outstanding) age++;
            chk("busy", busy, outstanding);
            chk("rsp_valid", rsp_valid, outstanding && age >= 2);
            chk("ops_done", ops_done, hs_count % (1 << CW));
            if (outstanding && age == 1) begin
                chk("exec_alu_f", alu_f, pend_f);
                chk("exec_alu_a", alu_a, pend_a);
                chk("exec_alu_b", alu_b, pend_b);
            end
            r0 = 1'b0;
            r1 = 1'b0;
            if (!outstanding) begin
                r0 = req0_valid && (!req1_valid || m_last);
                r1 = req1_valid && (!req0_valid || !m_last);
            end
            chk("req0_ready", req0_ready, r0);
            chk("req1_ready", req1_ready, r1);
            if (hold_valid && rsp_valid)
                chk("rsp_stable", {rsp_id, rsp_y, rsp_zf, rsp_of}, held);
            hold_valid = rsp_valid && !rsp_ready;
            held = {rsp_id, rsp_y, rsp_zf, rsp_of};
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_y", rsp_y, e.y);
                    chk("rsp_zf", rsp_zf, e.zf);
                    chk("rsp_of", rsp_of, e.of);
                end
                last_rsp = {rsp_id, rsp_y, rsp_zf, rsp_of};
                hs_count++;
                hs_cyc = cyc;
                outstanding = 1'b0;
            end
            if (req0_valid && req0_ready) begin
                expq.push_back({1'b0, alu_ref(req0_f, req0_a, req0_b)});
                pend_f = req0_f; pend_a = req0_a; pend_b = req0_b;
                m_last = 1'b0; outstanding = 1'b1; age = 0; acc0 = 1'b1;
                acc_cyc.push_back(cyc); acc_id.push_back(0);
            end else if (req1_valid && req1_ready) begin
                expq.push_back({1'b1, alu_ref(req1_f, req1_a, req1_b)});
                pend_f = req1_f; pend_a = req1_a; pend_b = req1_b;
                m_last = 1'b1; outstanding = 1'b1; age = 0; acc1 = 1'b1;
                acc_cyc.push_back(cyc); acc_id.push_back(1);
            end
        end
    end

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic new_req0();
        req0_f = 4'($urandom_range(0, 15)); req0_a = rand_op(); req0_b = rand_op();
    endtask

    task automatic new_req1();
        req1_f = 4'($urandom_range(0, 15)); req1_a = rand_op(); req1_b = rand_op();
    endtask

    task automatic issue(input bit id, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        if (id == 1'b0) begin req0_f = f; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else            begin req1_f = f; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        do begin
            @(posedge clk); #1; n++;
        end while (!(id ? acc1 : acc0) && n < 30);
        chk("issue_timeout", (id ? acc1 : acc0), 1);
        if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (outstanding && n < 60) begin
            @(posedge clk); n++;
        end
        #1;
        chk("idle_timeout", outstanding, 0);
    endtask

    initial begin
        int n;
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_f", alu_f, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_y, rsp_zf, rsp_of}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ops_done", ops_done, 0);
        rst_n = 1'b1;
        in_reset = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Single subtract producing zero
        issue(0, 4'b0110, 32'd5, 32'd5);
        wait_idle();
        chk("sub_zero", last_rsp, {1'b0, 32'd0, 1'b1, 1'b0});

        // Signed overflow on subtract
        issue(1, 4'b0110, 32'h8000_0000, 32'd1);
        wait_idle();
        chk("sub_ovf", last_rsp, {1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1});

        // Round-robin with both requesters continuously valid
        acc_cyc.delete(); acc_id.delete();
        new_req0(); new_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (acc_cyc.size() < 4 && n < 60) begin
            @(posedge clk); #1; n++;
            if (acc0) new_req0();
            if (acc1) new_req1();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", acc_cyc.size() >= 4, 1);
        if (acc_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_id", acc_id[i], i % 2);
            for (int i = 1; i < 4; i++) chk("rr_interval", acc_cyc[i] - acc_cyc[i-1], 3);
        end
        wait_idle();

        // Backpressure for 10 cycles with both requesters pending
        rsp_ready = 1'b0;
        issue(0, 4'b0010, 32'h7FFF_FFFF, 32'd1);
        new_req0(); new_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("bp_rsp_valid", rsp_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_busy", busy, 1);
        acc_cyc.delete();
        rsp_ready = 1'b1;
        n = 0;
        while (acc_cyc.size() == 0 && n < 10) begin @(posedge clk); #1; n++; end
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("bp_accept_after_hs", (acc_cyc.size() > 0) ? acc_cyc[0] - hs_cyc : -1, 1);
        rsp_ready = 1'b1;
        wait_idle();

        // Randomised traffic with random backpressure and valid drops
        new_req0(); new_req1();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (acc0 || !req0_valid) begin new_req0(); req0_valid = ($urandom_range(0, 2) != 0); end
            else if ($urandom_range(0, 9) == 0) req0_valid = 1'b0;
            if (acc1 || !req1_valid) begin new_req1(); req1_valid = ($urandom_range(0, 2) != 0); end
            else if ($urandom_range(0, 9) == 0) req1_valid = 1'b0;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while a response is held in DONE
        rsp_ready = 1'b0;
        issue(1, 4'b0001, 32'h1234, 32'h0F0F);
        n = 0;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("pre_rst_rsp_valid", rsp_valid, 1);
        @(negedge clk); #2;
        in_reset = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ops_done", ops_done, 0);
        expq.delete();
        outstanding = 1'b0; age = 0; m_last = 1'b1; hs_count = 0; hold_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_reset = 1'b0;
        acc_id.delete();
        new_req0(); new_req1();
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0;
        while (acc_id.size() == 0 && n < 10) begin @(posedge clk); #1; n++; end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("post_rst_tie_winner", (acc_id.size() > 0) ? acc_id[0] : -1, 0);
        rsp_ready = 1'b1;
        wait_idle();

        // Counter wrap: five more operations
        for (int i = 0; i < 5; i++) begin
            issue(i % 2, 4'($urandom_range(0, 15)), rand_op(), rand_op());
            wait_idle();
        end
        @(negedge clk);
        chk("wrap_ops_done", ops_done, 6 % (1 << CW));
        chk("scoreboard_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
